sram_arb_ctrl: RTL

- Sequenced arbiter and timing controller for the BaseRAM. The BaseRAM is shared between the IFU and LSU ports.
- Replaces the purely combinational sharing with a registered FSM. The FSM grants one requester, drives SRAM strobes with address setup/hold margins, captures read data and returns a one-cycle resp pulse.
- Sits between the core's IFU/LSU memory ports and the BaseRAM pins. ExtRAM and UART decoding stay outside.

---
 rtl/sram_arb_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/sram_arb_ctrl.sv
// BaseRAM arbiter/timing controller: grants IFU or LSU and sequences the SRAM strobes IDLE->SETUP->ACCESS->DONE.
// Optional macro SRAM_ARB_STARVE_GUARD_EN bounds consecutive LSU grants while the IFU waits.
module sram_arb_ctrl #(
    parameter int unsigned WAIT_CYCLES   = 1,
    parameter int unsigned LSU_BURST_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ifu_req_i,
    input  logic [31:0] ifu_addr_i,
    input  logic [31:0] ifu_wdata_i,
    input  logic [3:0]  ifu_be_n_i,
    input  logic        ifu_re_n_i,
    input  logic        ifu_we_n_i,
    output logic        ifu_resp_o,
    output logic [31:0] ifu_rdata_o,
    input  logic        lsu_req_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    input  logic [3:0]  lsu_be_n_i,
    input  logic        lsu_re_n_i,
    input  logic        lsu_we_n_i,
    output logic        lsu_resp_o,
    output logic [31:0] lsu_rdata_o,
    output logic [19:0] base_ram_addr,
    output logic [31:0] base_ram_wdata,
    input  logic [31:0] base_ram_rdata,
    output logic [3:0]  base_ram_be_n,
    output logic        base_ram_ce_n,
    output logic        base_ram_oe_n,
    output logic        base_ram_we_n
);
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DONE} state_t;
    typedef enum logic [1:0] {OP_NOP, OP_RD, OP_WR} op_t;

    state_t             r_state;
    op_t                r_op;
    logic               r_gnt_lsu;
    logic [CNT_W-1:0]   r_wait;

    logic               w_any_req;
    logic               w_pick_lsu;
    logic [31:0]        w_addr;
    logic [31:0]        w_wdata;
    logic [3:0]         w_be_n;
    logic               w_re_n;
    logic               w_we_n;
    op_t                w_op;
    logic               w_unused_addr;

    assign w_any_req = ifu_req_i | lsu_req_i;

`ifdef SRAM_ARB_STARVE_GUARD_EN
    logic [CNT_W-1:0]   r_burst;
    logic               w_force_ifu;

    assign w_force_ifu = ifu_req_i && lsu_req_i && (r_burst == CNT_W'(LSU_BURST_MAX));
    assign w_pick_lsu  = lsu_req_i && !w_force_ifu;

    // Counts LSU grants taken while the IFU was kept waiting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_burst <= '0;
        end else if (r_state == S_IDLE && w_any_req) begin
            if (w_pick_lsu && ifu_req_i) r_burst <= r_burst + CNT_W'(1);
            else                         r_burst <= '0;
        end
    end
`else
    logic w_unused_cfg;
    assign w_unused_cfg = (LSU_BURST_MAX == 0);
    assign w_pick_lsu   = lsu_req_i;
`endif

    assign w_addr  = w_pick_lsu ? lsu_addr_i  : ifu_addr_i;
    assign w_wdata = w_pick_lsu ? lsu_wdata_i : ifu_wdata_i;
    assign w_be_n  = w_pick_lsu ? lsu_be_n_i  : ifu_be_n_i;
    assign w_re_n  = w_pick_lsu ? lsu_re_n_i  : ifu_re_n_i;
    assign w_we_n  = w_pick_lsu ? lsu_we_n_i  : ifu_we_n_i;

    // Write beats read when both strobes are low
    assign w_op = !w_we_n ? OP_WR : (!w_re_n ? OP_RD : OP_NOP);

    assign w_unused_addr = ^{ifu_addr_i[31:22], ifu_addr_i[1:0], lsu_addr_i[31:22], lsu_addr_i[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_op           <= OP_NOP;
            r_gnt_lsu      <= 1'b0;
            r_wait         <= '0;
            base_ram_addr  <= '0;
            base_ram_wdata <= '0;
            base_ram_be_n  <= 4'b1111;
            base_ram_ce_n  <= 1'b1;
            base_ram_oe_n  <= 1'b1;
            base_ram_we_n  <= 1'b1;
            ifu_resp_o     <= 1'b0;
            ifu_rdata_o    <= '0;
            lsu_resp_o     <= 1'b0;
            lsu_rdata_o    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_gnt_lsu      <= w_pick_lsu;
                        r_op           <= w_op;
                        base_ram_addr  <= w_addr[21:2];
                        base_ram_wdata <= w_wdata;
                        base_ram_be_n  <= w_be_n;
                        base_ram_ce_n  <= 1'b0;
                        base_ram_oe_n  <= (w_op != OP_RD);
                        base_ram_we_n  <= 1'b1;
                        r_state        <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_wait        <= CNT_W'(WAIT_CYCLES - 1);
                    base_ram_oe_n <= (r_op != OP_RD);
                    base_ram_we_n <= (r_op != OP_WR);
                    r_state       <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (r_wait == '0) begin
                        // Last strobe cycle: sample read data straight into the response register
                        base_ram_ce_n <= 1'b1;
                        base_ram_oe_n <= 1'b1;
                        base_ram_we_n <= 1'b1;
                        if (r_gnt_lsu) begin
                            lsu_resp_o  <= 1'b1;
                            lsu_rdata_o <= (r_op == OP_RD) ? base_ram_rdata : 32'h0;
                        end else begin
                            ifu_resp_o  <= 1'b1;
                            ifu_rdata_o <= (r_op == OP_RD) ? base_ram_rdata : 32'h0;
                        end
                        r_state <= S_DONE;
                    end else begin
                        r_wait <= r_wait - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    ifu_resp_o <= 1'b0;
                    lsu_resp_o <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
